// File: rtl/diag_sequencer.sv
// diag_sequencer: 4-deep command FIFO feeding an EBUS diag strobe/write/sync sequencer.
module diag_sequencer #(
  parameter int         STROBE_CYCLES = 9,
  parameter int         GAP_CYCLES    = 4,
  parameter int         SYNC_WAIT     = 5,
  parameter int         SYNC_TRIES    = 5,
  parameter logic [6:0] IDLE_CODE     = 7'o000,
  parameter logic [6:0] STEP_CODE     = 7'o002
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_kind,
  input  logic [6:0]  cmd_func,
  input  logic [17:0] cmd_data,
  input  logic        a_change_coming_l,
  output logic [6:0]  ebus_ds,
  output logic        ebus_diag_strobe,
  output logic [17:0] ebus_data_rh,
  output logic        ebus_driving,
  output logic        busy,
  output logic        done,
  output logic        sync_err
);
  typedef enum logic [2:0] {IDLE, STROBE, GAP, SWAIT, SCHECK, SSTEP, SGAP} state_t;
  typedef struct packed {
    logic [1:0]  kind;
    logic [6:0]  func;
    logic [17:0] data;
  } cmd_t;
  localparam logic [15:0] T_STB  = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] T_GAP  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] T_WAIT = 16'(SYNC_WAIT - 1);
  localparam logic [7:0]  TRIES  = 8'(SYNC_TRIES);
  cmd_t        fifo_q [4];
  logic [1:0]  wr_q, rd_q;
  logic [2:0]  cnt_q;
  state_t      state_q;
  logic [15:0] tmr_q;
  logic [7:0]  steps_q;
  logic        step_next_q;
  logic [1:0]  acc_q;
  logic        push, pop;
  cmd_t        head;
  assign cmd_ready = cnt_q != 3'd4;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = state_q == IDLE && cnt_q != 3'd0;
  assign head      = fifo_q[rd_q];
  assign busy      = state_q != IDLE || cnt_q != 3'd0;
  always_ff @(posedge clk)
    if (push) fifo_q[wr_q] <= {cmd_kind, cmd_func, cmd_data};
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 2'd1;
      if (pop) rd_q <= rd_q + 2'd1;
      cnt_q <= cnt_q + {2'b0, push} - {2'b0, pop};
    end
  // acc_q[1] is the synchronized A CHANGE COMING L; resets to the inactive level
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) acc_q <= 2'b11;
    else acc_q <= {acc_q[0], a_change_coming_l};
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      state_q          <= IDLE;
      tmr_q            <= '0;
      steps_q          <= '0;
      step_next_q      <= 1'b0;
      ebus_ds          <= IDLE_CODE;
      ebus_diag_strobe <= 1'b0;
      ebus_data_rh     <= '0;
      ebus_driving     <= 1'b0;
      done             <= 1'b0;
      sync_err         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (pop) begin
          case (head.kind)
            2'd0, 2'd1: begin
              state_q          <= STROBE;
              tmr_q            <= T_STB;
              ebus_ds          <= head.func;
              ebus_diag_strobe <= 1'b1;
              ebus_driving     <= head.kind[0];
              ebus_data_rh     <= head.kind[0] ? head.data : '0;
            end
            2'd2: begin
              state_q     <= SWAIT;
              tmr_q       <= T_WAIT;
              steps_q     <= '0;
              step_next_q <= 1'b0;
            end
            default: done <= 1'b1;
          endcase
        end
        STROBE, SSTEP: if (tmr_q == '0) begin
          state_q          <= state_q == STROBE ? GAP : SGAP;
          tmr_q            <= T_GAP;
          ebus_ds          <= IDLE_CODE;
          ebus_diag_strobe <= 1'b0;
          ebus_driving     <= 1'b0;
          ebus_data_rh     <= '0;
        end else tmr_q <= tmr_q - 16'd1;
        GAP: if (tmr_q == '0) begin
          state_q <= IDLE;
          done    <= 1'b1;
        end else tmr_q <= tmr_q - 16'd1;
        SGAP: if (tmr_q == '0) begin
          state_q     <= SWAIT;
          tmr_q       <= T_WAIT;
          steps_q     <= steps_q + 8'd1;
          step_next_q <= 1'b0;
        end else tmr_q <= tmr_q - 16'd1;
        // the same settle wait precedes both a check and a step; step_next_q picks which
        SWAIT: if (tmr_q == '0) begin
          if (step_next_q) begin
            state_q          <= SSTEP;
            tmr_q            <= T_STB;
            ebus_ds          <= STEP_CODE;
            ebus_diag_strobe <= 1'b1;
          end else state_q <= SCHECK;
        end else tmr_q <= tmr_q - 16'd1;
        SCHECK: if (acc_q[1] || steps_q == TRIES) begin
          state_q  <= IDLE;
          done     <= 1'b1;
          sync_err <= sync_err | !acc_q[1];
        end else begin
          state_q     <= SWAIT;
          tmr_q       <= T_WAIT;
          step_next_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_diag_sequencer.sv
// tb_diag_sequencer: directed scoreboard bench for diag_sequencer strobe, write, sync and reset behaviour.
module tb_diag_sequencer;
  localparam logic [6:0] IDLE = 7'o000;
  localparam logic [6:0] STEP = 7'o002;
  localparam int SPC = 14;
  localparam int SYNC_SPC = 24;
  typedef struct {
    logic [6:0]  ds;
    logic        drv;
    logic [17:0] data;
    int          spacing;
  } exp_t;
  logic clk = 0, reset_l = 0, cmd_valid = 0, cmd_ready, a_cc = 1;
  logic [1:0]  cmd_kind = 0;
  logic [6:0]  cmd_func = 0;
  logic [17:0] cmd_data = 0;
  logic [6:0]  ebus_ds;
  logic        ebus_diag_strobe, ebus_driving, busy, done, sync_err;
  logic [17:0] ebus_data_rh;
  int tests = 0, fails = 0, cyc = 0, done_cnt = 0, done_cyc = 0, fall_cyc = 0, falls = 0, viol = 0, extra = 0;
  int st_len = 0, rise_cyc = 0, prev_rise = 0;
  logic in_st = 0, r_drv = 0;
  logic [6:0] r_ds = 0;
  logic [17:0] r_data = 0;
  exp_t exp_q[$];

  diag_sequencer dut (
    .clk(clk), .reset_l(reset_l), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_func(cmd_func), .cmd_data(cmd_data),
    .a_change_coming_l(a_cc), .ebus_ds(ebus_ds), .ebus_diag_strobe(ebus_diag_strobe),
    .ebus_data_rh(ebus_data_rh), .ebus_driving(ebus_driving), .busy(busy),
    .done(done), .sync_err(sync_err)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic [6:0] ds, input logic drv, input logic [17:0] d, input int sp);
    exp_q.push_back('{ds, drv, d, sp});
  endtask

  // advance to the next falling edge and observe the EBUS there
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!reset_l) begin
      in_st = 0;
      return;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ebus_diag_strobe) begin
      if (!in_st) begin
        in_st = 1; st_len = 0; rise_cyc = cyc;
        r_ds = ebus_ds; r_drv = ebus_driving; r_data = ebus_data_rh;
      end else if (ebus_ds !== r_ds || ebus_driving !== r_drv || ebus_data_rh !== r_data) viol++;
      st_len++;
    end else begin
      if (ebus_ds !== IDLE || ebus_driving !== 1'b0 || ebus_data_rh !== 18'd0) viol++;
      if (in_st) begin
        in_st = 0; falls++; fall_cyc = cyc;
        if (exp_q.size() == 0) extra++;
        else begin
          e = exp_q.pop_front();
          check("strobe_ds", 32'(r_ds), 32'(e.ds));
          check("strobe_drv", 32'(r_drv), 32'(e.drv));
          check("strobe_data", 32'(r_data), 32'(e.data));
          check("strobe_len", st_len, 9);
          if (e.spacing != 0) check("strobe_spacing", rise_cyc - prev_rise, e.spacing);
        end
        prev_rise = rise_cyc;
      end
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [6:0] f, input logic [17:0] d, output logic acc);
    cmd_valid = 1; cmd_kind = k; cmd_func = f; cmd_data = d;
    acc = cmd_ready;
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic wait_strobe(input int maxc);
    int n = 0;
    while (!ebus_diag_strobe && n < maxc) begin
      tick();
      n++;
    end
    check("strobe_timeout", 32'(ebus_diag_strobe), 1);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_scoreboard_left"}, exp_q.size(), 0);
    check({tag, "_extra_strobes"}, extra, 0);
    check({tag, "_invariant"}, viol, 0);
  endtask

  initial begin
    logic acc;
    int d0, f0, n;
    repeat (3) tick();
    check("rst_ds", 32'(ebus_ds), 32'(IDLE));
    check("rst_strobe", 32'(ebus_diag_strobe), 0);
    check("rst_driving", 32'(ebus_driving), 0);
    check("rst_data", 32'(ebus_data_rh), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sync_err", 32'(sync_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(cmd_ready), 1);
    // command presented while reset releases must be taken on the first edge
    d0 = done_cnt;
    cmd_valid = 1; cmd_kind = 0; cmd_func = 7'o010; cmd_data = 0;
    exp_push(7'o010, 0, 0, 0);
    reset_l = 1;
    @(posedge clk);
    #1 check("first_accept_busy", 32'(busy), 1);
    tick();
    cmd_valid = 0;
    wait_idle(100);
    check("func_done_count", done_cnt - d0, 1);
    check("func_gap_len", done_cyc - fall_cyc, 4);
    end_checks("func");

    d0 = done_cnt;
    push(1, 7'o044, 18'o000120, acc);
    check("write_accept", 32'(acc), 1);
    exp_push(7'o044, 1, 18'o000120, 0);
    wait_idle(100);
    check("write_done_count", done_cnt - d0, 1);
    check("write_gap_len", done_cyc - fall_cyc, 4);
    end_checks("write");

    d0 = done_cnt;
    push(0, 7'o001, 0, acc);
    exp_push(7'o001, 0, 0, 0);
    wait_strobe(10);
    for (int i = 0; i < 5; i++) begin
      logic [1:0] k;
      logic [17:0] d;
      k = 2'(i % 2);
      d = 18'(i * 3 + 1);
      push(k, 7'(7'o011 + i), d, acc);
      check("fifo_accept", 32'(acc), 32'(i < 4));
      if (i < 4) exp_push(7'(7'o011 + i), k[0], k[0] ? d : 18'd0, SPC);
    end
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    push(1, 7'o016, 18'o123456, acc);
    check("fifo_refill_accept", 32'(acc), 1);
    exp_push(7'o016, 1, 18'o123456, SPC);
    wait_idle(300);
    check("fifo_done_count", done_cnt - d0, 6);
    end_checks("fifo");

    d0 = done_cnt;
    f0 = falls;
    a_cc = 0;
    push(2, 0, 0, acc);
    exp_push(STEP, 0, 0, 0);
    exp_push(STEP, 0, 0, SYNC_SPC);
    n = 0;
    while (falls < f0 + 2 && n < 200) begin
      tick();
      n++;
    end
    a_cc = 1;
    wait_idle(200);
    check("sync2_steps", falls - f0, 2);
    check("sync2_done_count", done_cnt - d0, 1);
    check("sync2_err", 32'(sync_err), 0);
    end_checks("sync2");

    d0 = done_cnt;
    f0 = falls;
    a_cc = 0;
    push(2, 0, 0, acc);
    exp_push(STEP, 0, 0, 0);
    for (int i = 0; i < 4; i++) exp_push(STEP, 0, 0, SYNC_SPC);
    wait_idle(1000);
    check("syncx_steps", falls - f0, 5);
    check("syncx_done_count", done_cnt - d0, 1);
    check("syncx_err", 32'(sync_err), 1);
    end_checks("syncx");
    a_cc = 1;

    d0 = done_cnt;
    push(0, 7'o077, 0, acc);
    exp_push(7'o077, 0, 0, 0);
    wait_idle(100);
    check("after_err_done_count", done_cnt - d0, 1);
    check("err_sticky", 32'(sync_err), 1);
    end_checks("after_err");

    d0 = done_cnt;
    f0 = falls;
    push(3, 7'o077, 18'o777777, acc);
    wait_idle(20);
    check("rsvd_done_count", done_cnt - d0, 1);
    check("rsvd_no_strobe", falls - f0, 0);
    check("rsvd_ds", 32'(ebus_ds), 32'(IDLE));
    end_checks("rsvd");

    push(1, 7'o054, 18'o000777, acc);
    wait_strobe(10);
    push(0, 7'o020, 0, acc);
    push(0, 7'o021, 0, acc);
    tick();
    #2 reset_l = 0;
    #1;
    check("rstmid_strobe", 32'(ebus_diag_strobe), 0);
    check("rstmid_driving", 32'(ebus_driving), 0);
    check("rstmid_data", 32'(ebus_data_rh), 0);
    check("rstmid_ds", 32'(ebus_ds), 32'(IDLE));
    repeat (2) tick();
    reset_l = 1;
    #1;
    check("rstrel_busy", 32'(busy), 0);
    check("rstrel_ready", 32'(cmd_ready), 1);
    check("rstrel_sync_err", 32'(sync_err), 0);
    d0 = done_cnt;
    f0 = falls;
    repeat (40) tick();
    check("rstrel_no_strobe", falls - f0, 0);
    check("rstrel_no_done", done_cnt - d0, 0);
    end_checks("rstmid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/diag_sequencer.md
DIAG_SEQUENCER -- requirements
Module: diag_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- STROBE_CYCLES, 9, clocks diag_strobe is held per function.
- GAP_CYCLES, 4, idle clocks after each strobe.
- SYNC_WAIT, 5, settle clocks before each A CHANGE COMING sample.
- SYNC_TRIES, 5, maximum MBOX steps per sync command.
- IDLE_CODE, 7'o000, ds value when no function is active.
- STEP_CODE, 7'o002, ds value for the single-step-clock function.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, CLK 10/11 CLK H; sole clock; all logic on posedge.
- reset_l, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, FIFO can accept a command.
- cmd_kind, in, 2, 0=func, 1=write, 2=sync, 3=reserved.
- cmd_func, in, 7, diag function code (ds[0:6]).
- cmd_data, in, 18, write data for EBUS RH [18:35].
- a_change_coming_l, in, 1, MBC3 A CHANGE COMING A L (active low).
- ebus_ds, out, 7, diag function select.
- ebus_diag_strobe, out, 1, diag strobe.
- ebus_data_rh, out, 18, EBUS data [18:35] when driving.
- ebus_driving, out, 1, sequencer owns EBUS data.
- busy, out, 1, FIFO non-empty or sequence in progress.
- done, out, 1, one-clock pulse when a command completes.
- sync_err, out, 1, sticky; sync exhausted SYNC_TRIES.

Function
REQ-003 Command FIFO depth 4; push when cmd_valid && cmd_ready; cmd_ready = !full; push while full is never accepted.
REQ-004 Simultaneous push and pop allowed when not full; occupancy unchanged; pointers wrap modulo 4.
REQ-005 Commands execute strictly in order, one at a time; pop occurs on the IDLE->first-state transition.
REQ-006 States: IDLE, STROBE, GAP, SWAIT, SCHECK, SSTEP, SGAP.
REQ-007 func (kind 0): IDLE->STROBE; ebus_ds=cmd_func, ebus_diag_strobe=1 for exactly STROBE_CYCLES clocks; ebus_driving=0.
REQ-008 write (kind 1): as REQ-007, plus ebus_driving=1 and ebus_data_rh=cmd_data for the same STROBE_CYCLES clocks.
REQ-009 STROBE->GAP: ds=IDLE_CODE, strobe=0, driving=0, ebus_data_rh=0 for GAP_CYCLES clocks; then done pulses and state returns to IDLE.
REQ-010 Strobe-to-next-strobe minimum spacing is STROBE_CYCLES+GAP_CYCLES+1 clocks (one IDLE clock between commands).
REQ-011 sync (kind 2): step counter=0; SWAIT for SYNC_WAIT clocks; SCHECK samples a_change_coming_l.
REQ-012 SCHECK: a_change_coming_l=1 -> done, IDLE; else if counter==SYNC_TRIES -> set sync_err, done, IDLE; else SWAIT (SYNC_WAIT clocks) then SSTEP.
REQ-013 SSTEP: ds=STEP_CODE, strobe=1 for STROBE_CYCLES; SGAP for GAP_CYCLES; counter++; then SWAIT->SCHECK.
REQ-014 Reserved kind 3: pop, no EBUS activity, done pulse next clock.
REQ-015 sync_err clears only on reset; subsequent commands still execute.
REQ-016 a_change_coming_l is passed through a 2-flop synchronizer before use.
REQ-017 Outputs are registered; no combinational path from cmd_* to ebus_*.
REQ-018 busy=1 whenever state!=IDLE or FIFO non-empty.

Reset
REQ-019 reset_l low asynchronously forces state=IDLE, FIFO empty, counters 0, ebus_ds=IDLE_CODE, strobe=0, driving=0, data_rh=0, done=0, sync_err=0, busy=0; cmd_ready=1.
REQ-020 Reset mid-strobe drops ebus_diag_strobe and ebus_driving immediately; the in-flight command and queued commands are discarded.
REQ-021 First command is accepted on the first posedge after reset_l deasserts.

Verification
REQ-022 Push func 7'o010 -> ds=7'o010, strobe high exactly 9 clocks, 4 gap clocks with ds=0, single done pulse; ebus_driving never 1.
REQ-023 Push write 7'o044 data 18'o000120 -> driving=1 and data_rh=000120 coincident with all 9 strobe clocks, 0 in gap.
REQ-024 Push 5 commands back-to-back with execution stalled -> 4 accepted, cmd_ready=0 on fifth; all 4 execute in order, 4 done pulses.
REQ-025 sync with a_change_coming_l held 0 for 2 steps then 1 -> exactly 2 STEP_CODE strobes, done, sync_err=0; held 0 forever -> exactly 5 steps, sync_err=1.
REQ-026 Assert reset_l low on strobe clock 4 of a write -> strobe, driving 0 same instant; after release, FIFO empty, busy=0, cmd_ready=1.
